// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared oversample constants, FSM state encodings and baud-rate math for uart_link_ctrl
package uart_link_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID = 8;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [0:0] WAIT_A = 1'b0, WAIT_B = 1'b1;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud * MID) / (baud * OVERSAMPLE);
  endfunction
  function automatic int calc_bit_cyc(input int clk_hz, input int baud);
    return OVERSAMPLE * calc_div(clk_hz, baud);
  endfunction
endpackage

// File: rtl/uart_link_baud.sv
// uart_link_baud: oversample tick every DIV clocks; ports clk, reset (async active-low), restart (sync phase restart), tick
module uart_link_baud #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt;
  assign tick = !restart && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: 8N1 UART link; rx bytes paired into int1/int2 with input_ready strobe, int3 sent on output_ready with occupied busy flag; clk, reset (async active-low)
module uart_link_ctrl import uart_link_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 9600,
  parameter int PAIR_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] int1,
  output logic [7:0] int2,
  output logic       input_ready,
  input  logic [7:0] int3,
  input  logic       output_ready,
  output logic       occupied
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BIT_CYC = calc_bit_cyc(CLK_HZ, BAUD);
  localparam int CW = $clog2(BIT_CYC);
  localparam int PW = $clog2(PAIR_TIMEOUT + 1);
  logic rx_m, rx_s, rx_d, tick;
  logic [1:0] rs, ts;
  logic [3:0] tcnt;
  logic [2:0] rbit, tbit;
  logic [7:0] rsh, tsh, byte_a;
  logic [0:0] ps;
  logic [PW-1:0] tmo;
  logic [CW-1:0] tcyc;
  logic fall, restart, at_mid, at_end, bit_time, deliver, ferr, tend, tload;
  assign fall = rx_d && !rx_s;
  assign restart = rs == RX_IDLE && fall;
  assign at_mid = tick && tcnt == 4'(MID - 1);
  assign at_end = tick && tcnt == 4'(OVERSAMPLE - 1);
  assign bit_time = rs == RX_IDLE && at_end;
  assign deliver = rs == RX_STOP && at_end && rx_s;
  assign ferr = rs == RX_STOP && at_end && !rx_s;
  assign tend = tcyc == CW'(BIT_CYC - 1);
  assign tload = output_ready && (ts == TX_IDLE || (ts == TX_STOP && tend));
  uart_link_baud #(.DIV(DIV)) u_baud (
    .clk(clk),
    .reset(reset),
    .restart(restart),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) {rx_m, rx_s, rx_d} <= 3'b111;
    else {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rs <= RX_IDLE;
      tcnt <= '0;
      rbit <= '0;
      rsh <= '0;
    end else begin
      tcnt <= restart ? '0 : tick ? tcnt + 1'b1 : tcnt;
      case (rs)
        RX_IDLE: rs <= fall ? RX_START : RX_IDLE;
        RX_START: if (at_mid) begin
          rs <= rx_s ? RX_IDLE : RX_DATA;
          tcnt <= '0;
          rbit <= '0;
        end
        RX_DATA: if (at_end) begin
          rsh <= {rx_s, rsh[7:1]};
          rbit <= rbit + 1'b1;
          rs <= rbit == 3'd7 ? RX_STOP : RX_DATA;
        end
        default: rs <= at_end ? RX_IDLE : RX_STOP;
      endcase
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ps <= WAIT_A;
      tmo <= '0;
      byte_a <= '0;
      int1 <= '0;
      int2 <= '0;
      input_ready <= 1'b0;
    end else begin
      input_ready <= deliver && ps == WAIT_B;
      if (ferr) ps <= WAIT_A;
      else if (deliver && ps == WAIT_A) begin
        ps <= WAIT_B;
        byte_a <= rsh;
        tmo <= PW'(PAIR_TIMEOUT);
      end else if (deliver) begin
        ps <= WAIT_A;
        int1 <= byte_a;
        int2 <= rsh;
      end else if (ps == WAIT_B && bit_time) begin
        ps <= tmo == PW'(1) ? WAIT_A : WAIT_B;
        tmo <= tmo - 1'b1;
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ts <= TX_IDLE;
      tx <= 1'b1;
      occupied <= 1'b0;
      tcyc <= '0;
      tbit <= '0;
      tsh <= '0;
    end else if (tload) begin
      ts <= TX_START;
      tx <= 1'b0;
      occupied <= 1'b1;
      tsh <= int3;
      tcyc <= '0;
      tbit <= '0;
    end else if (ts != TX_IDLE) begin
      tcyc <= tend ? '0 : tcyc + 1'b1;
      if (tend)
        case (ts)
          TX_START: begin
            ts <= TX_DATA;
            tx <= tsh[0];
            tsh <= tsh >> 1;
          end
          TX_DATA: begin
            ts <= tbit == 3'd7 ? TX_STOP : TX_DATA;
            tx <= tbit == 3'd7 ? 1'b1 : tsh[0];
            tsh <= tsh >> 1;
            tbit <= tbit + 1'b1;
          end
          default: begin
            ts <= TX_IDLE;
            tx <= 1'b1;
            occupied <= 1'b0;
          end
        endcase
    end
endmodule

// File: tb/tb_uart_link_ctrl.sv
// tb_uart_link_ctrl: randomized self-checking bench for uart_link_ctrl against a byte-level pairing model
module tb_uart_link_ctrl;
  localparam int PT = 4;
  localparam int BC = 160;
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1, output_ready = 1'b0;
  logic [7:0] int3 = 8'h00;
  logic tx, input_ready, occupied;
  logic [7:0] int1, int2;
  int checks = 0, errors = 0, cyc = 0, ir_wide = 0, gap_acc = 100;
  bit ir_prev = 1'b0, pend = 1'b0;
  logic [7:0] pa;
  logic [15:0] got_q[$], exp_q[$];
  int got_t[$];
  uart_link_ctrl #(.CLK_HZ(1_600_000), .BAUD(10_000), .PAIR_TIMEOUT(PT)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .tx(tx),
    .int1(int1),
    .int2(int2),
    .input_ready(input_ready),
    .int3(int3),
    .output_ready(output_ready),
    .occupied(occupied)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (input_ready) begin
      got_q.push_back({int1, int2});
      got_t.push_back(cyc);
    end
    if (input_ready && ir_prev) ir_wide++;
    ir_prev = input_ready;
  end
  task automatic idle(input int bits);
    repeat (bits * BC) @(negedge clk);
    gap_acc += bits;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (pend && gap_acc >= PT) pend = 1'b0;
    if (!stop) pend = 1'b0;
    else if (pend) begin
      exp_q.push_back({pa, b});
      pend = 1'b0;
    end else begin
      pend = 1'b1;
      pa = b;
    end
    gap_acc = 0;
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BC) @(negedge clk);
    end
    rx = 1'b1;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL reset_occupied got %b want 0", occupied); end
    checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL reset_input_ready got %b want 0", input_ready); end
    checks++; if ({int1, int2} !== 16'h0000) begin errors++; $display("FAIL reset_ints got %h want 0000", {int1, int2}); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_pair;
    int t0;
    send_byte(8'h3C, 1'b1, t0);
    idle(2);
    send_byte(8'hA5, 1'b1, t0);
    idle(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL pair_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL pair_data%0d got %h want %h", i, got_q[i], exp_q[i]); end end
    checks++; if (got_t.size() == 0 || got_t[0] < t0 + 1521 || got_t[0] > t0 + 1526) begin errors++; $display("FAIL pair_time got %0d want %0d..%0d", got_t.size() == 0 ? -1 : got_t[0], t0 + 1521, t0 + 1526); end
    checks++; if (ir_wide !== 0) begin errors++; $display("FAIL strobe_width got %0d wide pulses want 0", ir_wide); end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask
  task automatic test_timeout;
    int t0;
    send_byte(8'h11, 1'b1, t0);
    idle(6);
    send_byte(8'h22, 1'b1, t0);
    idle(1);
    send_byte(8'h33, 1'b1, t0);
    idle(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_data%0d got %h want %h", i, got_q[i], exp_q[i]); end end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask
  task automatic test_framing;
    int t0;
    send_byte(8'h55, 1'b0, t0);
    idle(1);
    send_byte(8'h01, 1'b1, t0);
    idle(1);
    send_byte(8'h02, 1'b1, t0);
    idle(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL framing_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL framing_data%0d got %h want %h", i, got_q[i], exp_q[i]); end end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask
  task automatic test_glitch;
    int t0;
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    idle(6);
    send_byte(a, 1'b1, t0);
    @(negedge clk);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (130) @(negedge clk);
    gap_acc += 1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_delivery got %0d strobes want 0", got_q.size()); end
    send_byte(b, 1'b1, t0);
    idle(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_data%0d got %h want %h", i, got_q[i], exp_q[i]); end end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask
  task automatic test_random;
    int t0;
    int gs[4];
    gs = '{0, 1, 2, 6};
    for (int n = 0; n < 8; n++) begin
      idle(gs[$urandom_range(0, 3)]);
      send_byte(8'($urandom), $urandom_range(0, 7) != 0, t0);
    end
    idle(6);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_data%0d got %h want %h", i, got_q[i], exp_q[i]); end end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask
  task automatic test_tx;
    logic [9:0] f;
    int n;
    f = {1'b1, 8'hC3, 1'b0};
    n = 0;
    @(negedge clk);
    int3 = 8'hC3;
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    int3 = 8'hFF;
    for (int i = 0; i < 1800; i++) begin
      if (i % BC == BC / 2 && i < 10 * BC) begin
        checks++; if (tx !== f[i / BC]) begin errors++; $display("FAIL tx_bit%0d got %b want %b", i / BC, tx, f[i / BC]); end
      end
      if (occupied) n++;
      output_ready = i == 800;
      @(negedge clk);
    end
    checks++; if (n !== 1600) begin errors++; $display("FAIL occupied_len got %0d want 1600", n); end
    checks++; if ({tx, occupied} !== 2'b10) begin errors++; $display("FAIL tx_idle got tx=%b occ=%b want tx=1 occ=0", tx, occupied); end
  endtask
  task automatic test_back_to_back;
    logic [19:0] f;
    f = {1'b1, 8'h96, 1'b0, 1'b1, 8'h5A, 1'b0};
    @(negedge clk);
    int3 = 8'h5A;
    output_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3400; i++) begin
      if (i == 100) int3 = 8'h96;
      if (i == 1700) output_ready = 1'b0;
      if (i % BC == BC / 2 && i < 20 * BC) begin
        checks++; if (tx !== f[i / BC]) begin errors++; $display("FAIL b2b_bit%0d got %b want %b", i / BC, tx, f[i / BC]); end
      end
      @(negedge clk);
    end
    checks++; if ({tx, occupied} !== 2'b10) begin errors++; $display("FAIL b2b_end got tx=%b occ=%b want tx=1 occ=0", tx, occupied); end
  endtask
  task automatic test_reset_mid;
    int t0;
    @(negedge clk);
    int3 = 8'h0F;
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    fork
      begin
        repeat (700) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", tx); end
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL rst_mid_occupied got %b want 0", occupied); end
        checks++; if ({int1, int2} !== 16'h0000) begin errors++; $display("FAIL rst_mid_ints got %h want 0000", {int1, int2}); end
      end
    join_none
    send_byte(8'h77, 1'b1, t0);
    pend = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    send_byte(8'hE1, 1'b1, t0);
    idle(1);
    send_byte(8'h4B, 1'b1, t0);
    idle(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_pair_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_pair_data%0d got %h want %h", i, got_q[i], exp_q[i]); end end
    checks++; if ({tx, occupied} !== 2'b10) begin errors++; $display("FAIL rst_tx_idle got tx=%b occ=%b want tx=1 occ=0", tx, occupied); end
    checks++; if (ir_wide !== 0) begin errors++; $display("FAIL strobe_width_end got %0d wide pulses want 0", ir_wide); end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask
  initial begin
    test_reset;
    test_pair;
    test_timeout;
    test_framing;
    test_glitch;
    test_random;
    test_tx;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
